fb_bank_ctrl: RTL and testbench
===============================

// Module: fb_bank_ctrl
// PURPOSE
//  Ping-pong frame-buffer controller between the camera pixel FIFO and a 2-bank frame BRAM.
//  Drains the FIFO into the current write bank and counts pixels to detect frame completion.
//  Swaps banks only on the display's start-of-frame, so the reader never sees a torn frame.
//  Sits between the capture FIFO and the dual-port frame BRAM; the display path owns BRAM read addressing.
// PARAMETERS
//  DATA_WIDTH    12      pixel width
//  FRAME_PIXELS  307200  pixels per frame (640x480)
//  ADDR_W        19      per-bank address width, >= clog2(FRAME_PIXELS)
// PORTS
//  i_clk            in   1             clock
//  i_rstn           in   1             reset, synchronous, active-low
//  i_flush          in   1             sync flush: abort current write frame
//  o_rd             out  1             FIFO read strobe (registered)
//  i_almostempty    in   1             FIFO almost-empty flag
//  i_fifo_data      in   DATA_WIDTH    FIFO read data, valid the cycle after o_rd
//  o_wr             out  1             BRAM write enable
//  o_waddr          out  ADDR_W+1      BRAM write address {wbank, pixel_addr}
//  o_wdata          out  DATA_WIDTH    BRAM write data (combinational pass-through of i_fifo_data)
//  i_rd_sof         in   1             1-cycle display start-of-frame pulse, already in i_clk domain
//  o_rbank          out  1             bank the display must read (MSB of its read address)
//  o_frame_pending  out  1             completed frame waiting for swap
//  o_frame_cnt      out  16            frames handed to display, wraps
//  o_drop_cnt       out  16            frames discarded (FB_FRAME_DROP_EN only, else 0)
// BEHAVIOUR
//  Reset: o_rd=0, o_wr=0, o_waddr=0, wbank=0, o_rbank=1, o_frame_pending=0, counters=0, state=WRITE.
//  o_rd=1 in WRITE when !i_almostempty && rd_cnt<FRAME_PIXELS; rd_cnt++ per o_rd.
//  o_wr = o_rd delayed by 1 cycle; pixel_addr advances by 1 after each o_wr; first write is at addr 0.
//  States:
//   - WRITE: issues reads until rd_cnt==FRAME_PIXELS -> DRAIN.
//   - DRAIN: waits for the final o_wr (addr FRAME_PIXELS-1); sets pending -> PEND.
//   - PEND: o_rd=0 (FIFO backs up) until swap.
//  Swap on i_rd_sof with pending:
//   - o_rbank<=wbank, wbank<=~wbank, pending<=0, rd_cnt/pixel_addr<=0, o_frame_cnt++, -> WRITE.
//  i_rd_sof without pending: no change; display re-reads the old o_rbank.
//  i_rd_sof in the same cycle as the final o_wr: swap takes effect that cycle; pending never seen high.
//  o_rbank changes only in the cycle after an i_rd_sof; never mid-display-frame.
//  i_flush: as reset except o_rbank, wbank, o_frame_cnt and o_drop_cnt are kept; any pending frame is kept.
//  Flush during PEND: state stays PEND. Flush has priority over i_rd_sof in the same cycle.
//  A write in flight when flush or reset hits is dropped: o_wr=0 on the next cycle.
//  pixel_addr never exceeds FRAME_PIXELS-1; counters wrap mod 2^16.
// CONFIGURATION
//  FB_FRAME_DROP_EN defined:
//   - PEND does not stall: if !i_almostempty, rewrite the completed frame in place.
//   - pending<=0, rd_cnt/pixel_addr<=0, o_drop_cnt++, -> WRITE.
//   - Display always receives the newest frame; the FIFO never backs up.
//  FB_FRAME_DROP_EN not defined:
//   - PEND stalls as above; o_drop_cnt tied to 0.
// STRUCTURE
//  Package fb_pkg: FRAME_PIXELS, ADDR_W, state encoding (WRITE/DRAIN/PEND), bank-select type.
//  Sub-module fb_pix_counter: saturating rd_cnt plus the pixel_addr counter with clear/inc.
//  The rest is one FSM plus the bank/swap registers.
// TESTING (FRAME_PIXELS=16 unless noted)
//  - Reset, FIFO kept non-almost-empty -> 16 o_rd; o_wr at addr 0..15 one cycle later; pending=1; o_rbank=1.
//  - PEND, FIFO full, i_rd_sof pulse -> next cycle o_rbank=0, o_frame_cnt=1; writes resume at o_waddr={1,0}.
//  - i_rd_sof in the cycle of the final write -> immediate swap; pending stays 0; o_frame_cnt=1.
//  - i_almostempty toggled every 3 cycles -> no o_rd while set; addresses contiguous; exactly 16 writes.
//  - i_flush after 7 writes -> o_rd=0; next write at addr 0 in the same bank; o_rbank unchanged.
//  - FB_FRAME_DROP_EN, 3 frames with no i_rd_sof -> o_drop_cnt=2, o_rbank=1, pending=1 after frame 3.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: shared definitions for the ping-pong frame-buffer controller.
//   FB_DATA_WIDTH / FB_FRAME_PIXELS / FB_ADDR_W : default geometry (640x480, 12-bit pixels)
//   fb_state_e : controller state encoding (WRITE / DRAIN / PEND)
//   fb_bank_t  : bank select (one of two BRAM halves)
package fb_pkg;

    localparam int FB_DATA_WIDTH   = 12;
    localparam int FB_FRAME_PIXELS = 307200;
    localparam int FB_ADDR_W       = 19;

    typedef enum logic [1:0] {
        ST_WRITE = 2'd0,  // issuing FIFO reads for the current frame
        ST_DRAIN = 2'd1,  // all reads issued, waiting for the last write to land
        ST_PEND  = 2'd2   // frame complete, waiting for the display to take it
    } fb_state_e;

    typedef logic fb_bank_t;

endpackage

// File: rtl/fb_bank_ctrl_if.sv
// fb_bank_ctrl_if: pixel path between capture FIFO, controller and frame BRAM.
//   rd / almostempty / fifo_data : FIFO read side (data valid the cycle after rd)
//   wr / waddr / wdata           : BRAM write side, waddr = {bank, pixel_addr}
// master = controller, slave = FIFO/BRAM side.
interface fb_bank_ctrl_if #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_W     = 19
);
    logic                  rd;
    logic                  almostempty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  wr;
    logic [ADDR_W:0]       waddr;
    logic [DATA_WIDTH-1:0] wdata;

    modport master (output rd, wr, waddr, wdata, input almostempty, fifo_data);
    modport slave  (input rd, wr, waddr, wdata, output almostempty, fifo_data);
endinterface

// File: rtl/fb_pix_counter.sv
// fb_pix_counter: per-frame read and write position counters.
//   i_clk, i_rstn   : clock, synchronous active-low reset
//   i_clr           : clear both counters (frame restart), wins over increments
//   i_rd_inc        : one FIFO read issued
//   i_wr_inc        : one BRAM write performed
//   o_pixel_addr    : address of the next BRAM write within the bank
//   o_rd_done       : all FRAME_PIXELS reads issued
//   o_last_addr     : o_pixel_addr sits on the final pixel
// Both counters saturate so a stray strobe can never walk past the frame.
module fb_pix_counter
    import fb_pkg::*;
#(
    parameter int FRAME_PIXELS = FB_FRAME_PIXELS,
    parameter int ADDR_W       = FB_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_clr,
    input  logic              i_rd_inc,
    input  logic              i_wr_inc,
    output logic [ADDR_W-1:0] o_pixel_addr,
    output logic              o_rd_done,
    output logic              o_last_addr
);
    localparam logic [ADDR_W:0]   RD_MAX   = (ADDR_W+1)'(FRAME_PIXELS);
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(FRAME_PIXELS - 1);

    logic [ADDR_W:0]   rd_cnt_d, rd_cnt_q;
    logic [ADDR_W-1:0] pixel_addr_d, pixel_addr_q;

    always_comb begin
        rd_cnt_d     = rd_cnt_q;
        pixel_addr_d = pixel_addr_q;
        if (i_clr) begin
            rd_cnt_d     = '0;
            pixel_addr_d = '0;
        end else begin
            if (i_rd_inc && rd_cnt_q != RD_MAX)
                rd_cnt_d = rd_cnt_q + 1'b1;
            if (i_wr_inc && pixel_addr_q != ADDR_MAX)
                pixel_addr_d = pixel_addr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            rd_cnt_q     <= '0;
            pixel_addr_q <= '0;
        end else begin
            rd_cnt_q     <= rd_cnt_d;
            pixel_addr_q <= pixel_addr_d;
        end
    end

    assign o_pixel_addr = pixel_addr_q;
    assign o_rd_done    = (rd_cnt_q == RD_MAX);
    assign o_last_addr  = (pixel_addr_q == ADDR_MAX);
endmodule

// File: rtl/fb_bank_ctrl.sv
// fb_bank_ctrl: ping-pong frame-buffer controller, capture FIFO -> 2-bank BRAM.
//   i_clk, i_rstn     : clock, synchronous active-low reset
//   i_flush           : abort the frame being written (pending frame survives)
//   bus (master)      : FIFO read strobe/data in, BRAM write enable/address/data out
//   i_rd_sof          : display start-of-frame pulse; the only point banks swap
//   o_rbank           : bank the display reads
//   o_frame_pending   : completed frame waiting for the display
//   o_frame_cnt       : frames handed to the display (wraps)
//   o_drop_cnt        : frames overwritten before the display took them (wraps)
// Build option FB_FRAME_DROP_EN: a pending frame is overwritten in place when
// new pixels arrive instead of stalling the FIFO; without it o_drop_cnt stays 0.
module fb_bank_ctrl
    import fb_pkg::*;
#(
    parameter int DATA_WIDTH   = FB_DATA_WIDTH,
    parameter int FRAME_PIXELS = FB_FRAME_PIXELS,
    parameter int ADDR_W       = FB_ADDR_W
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_flush,
    input  logic          i_rd_sof,
    fb_bank_ctrl_if.master bus,
    output logic          o_rbank,
    output logic          o_frame_pending,
    output logic [15:0]   o_frame_cnt,
    output logic [15:0]   o_drop_cnt
);
    fb_state_e   state_d, state_q;
    fb_bank_t    wbank_d, wbank_q;
    fb_bank_t    rbank_d, rbank_q;
    logic        pending_d, pending_q;
    logic        rd_d, rd_q;
    logic        wr_d, wr_q;
    logic [15:0] frame_cnt_d, frame_cnt_q;
    logic [15:0] drop_cnt_d, drop_cnt_q;

    logic              rd_req, swap, drop, clr;
    logic              rd_done, last_addr, final_wr;
    logic [ADDR_W-1:0] pixel_addr;
    logic [DATA_WIDTH-1:0] wdata;

    fb_pix_counter #(
        .FRAME_PIXELS (FRAME_PIXELS),
        .ADDR_W       (ADDR_W)
    ) u_cnt (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_clr        (clr),
        .i_rd_inc     (rd_req),
        .i_wr_inc     (wr_q),
        .o_pixel_addr (pixel_addr),
        .o_rd_done    (rd_done),
        .o_last_addr  (last_addr)
    );

    // The write landing on the last pixel address completes the frame.
    assign final_wr = wr_q && last_addr;
    assign clr      = i_flush || swap || drop;

    always_comb begin
        state_d     = state_q;
        wbank_d     = wbank_q;
        rbank_d     = rbank_q;
        pending_d   = pending_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        rd_req      = 1'b0;
        swap        = 1'b0;
        drop        = 1'b0;
        wr_d        = rd_q;

        if (i_flush) begin
            // Kill the in-flight read's write; a finished frame stays pending.
            wr_d    = 1'b0;
            state_d = (state_q == ST_PEND) ? ST_PEND : ST_WRITE;
        end else begin
            case (state_q)
                ST_WRITE: begin
                    rd_req = !bus.almostempty && !rd_done;
                    if (rd_done)
                        state_d = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (final_wr) begin
                        // A start-of-frame coinciding with the last write swaps
                        // straight away; pending is never raised.
                        if (i_rd_sof) begin
                            swap = 1'b1;
                        end else begin
                            pending_d = 1'b1;
                            state_d   = ST_PEND;
                        end
                    end
                end
                ST_PEND: begin
                    if (i_rd_sof) begin
                        swap = 1'b1;
                    end
`ifdef FB_FRAME_DROP_EN
                    else if (!bus.almostempty) begin
                        drop = 1'b1;
                    end
`endif
                end
                default: state_d = ST_WRITE;
            endcase

            if (swap) begin
                rbank_d     = wbank_q;
                wbank_d     = ~wbank_q;
                pending_d   = 1'b0;
                frame_cnt_d = frame_cnt_q + 16'd1;
                state_d     = ST_WRITE;
            end
            if (drop) begin
                // Rewrite the same bank; display keeps its current frame.
                pending_d  = 1'b0;
                drop_cnt_d = drop_cnt_q + 16'd1;
                state_d    = ST_WRITE;
            end
        end
        rd_d = rd_req;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q     <= ST_WRITE;
            wbank_q     <= 1'b0;
            rbank_q     <= 1'b1;
            pending_q   <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            wbank_q     <= wbank_d;
            rbank_q     <= rbank_d;
            pending_q   <= pending_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign wdata           = bus.fifo_data;
    assign bus.wdata       = wdata;
    assign bus.rd          = rd_q;
    assign bus.wr          = wr_q;
    assign bus.waddr       = {wbank_q, pixel_addr};
    assign o_rbank         = rbank_q;
    assign o_frame_pending = pending_q;
    assign o_frame_cnt     = frame_cnt_q;
    assign o_drop_cnt      = drop_cnt_q;
endmodule

// File: tb/tb_fb_bank_ctrl.sv
// tb_fb_bank_ctrl: directed bench for fb_bank_ctrl with a 16-pixel frame.
// A frame-level model (reads issued, writes landed, pending, banks, counters)
// is advanced every clock and compared against the DUT on every falling edge;
// directed scenarios add literal expectations at the interesting points.
// Define FB_FRAME_DROP_EN to run the frame-drop scenario instead.
module tb_fb_bank_ctrl;
    localparam int N  = 16;
    localparam int AW = 4;
    localparam int DW = 12;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic flush = 1'b0;
    logic sof = 1'b0;
    logic rbank, pend;
    logic [15:0] fcnt, dcnt;

    fb_bank_ctrl_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus ();

    fb_bank_ctrl #(
        .DATA_WIDTH   (DW),
        .FRAME_PIXELS (N),
        .ADDR_W       (AW)
    ) dut (
        .i_clk           (clk),
        .i_rstn          (rstn),
        .i_flush         (flush),
        .i_rd_sof        (sof),
        .bus             (bus),
        .o_rbank         (rbank),
        .o_frame_pending (pend),
        .o_frame_cnt     (fcnt),
        .o_drop_cnt      (dcnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) bus.fifo_data <= DW'($urandom);

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        wbank;
        logic        rbank;
        logic        pend;
        int          reads;
        int          writes;
        logic [15:0] fcnt;
        logic [15:0] dcnt;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mstep(mdl_t c, logic rst_n, logic fl, logic sf, logic ae);
        mdl_t n;
        logic done;
        n    = c;
        n.rd = 1'b0;
        n.wr = 1'b0;
        done = 1'b0;
        if (!rst_n) begin
            n.wbank = 1'b0; n.rbank = 1'b1; n.pend = 1'b0;
            n.reads = 0; n.writes = 0; n.fcnt = '0; n.dcnt = '0;
        end else if (fl) begin
            n.reads = 0; n.writes = 0;
        end else begin
            if (c.wr) n.writes = c.writes + 1;
            done = c.wr && (n.writes == N);
            n.rd = !c.pend && (c.reads < N) && !ae;
            if (n.rd) n.reads = c.reads + 1;
            n.wr = c.rd;
            if (sf && (c.pend || done)) begin
                n.rbank = c.wbank; n.wbank = ~c.wbank; n.pend = 1'b0;
                n.reads = 0; n.writes = 0; n.fcnt = c.fcnt + 16'd1;
            end else if (done) begin
                n.pend = 1'b1;
            end
`ifdef FB_FRAME_DROP_EN
            else if (c.pend && !ae) begin
                n.pend = 1'b0; n.reads = 0; n.writes = 0; n.dcnt = c.dcnt + 16'd1;
            end
`endif
        end
        return n;
    endfunction

    always @(posedge clk) m <= mstep(m, rstn, flush, sof, bus.almostempty);

    // ---------------- compare + monitor ----------------
    logic       chk_en = 1'b0;
    int         wr_total = 0;
    int         rd_total = 0;
    int         breaks = 0;
    int         pend_rise = 0;
    logic       pend_prev = 1'b0;
    logic [AW:0] last_addr = '0;
    logic [AW:0] exp_addr;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("o_rd", bus.rd, m.rd);
            chk("o_wr", bus.wr, m.wr);
            chk("o_rbank", rbank, m.rbank);
            chk("o_frame_pending", pend, m.pend);
            chk("o_frame_cnt", fcnt, m.fcnt);
            chk("o_drop_cnt", dcnt, m.dcnt);
            if (m.wr) begin
                exp_addr = {m.wbank, m.writes[AW-1:0]};
                chk("o_waddr", bus.waddr, exp_addr);
                chk("o_wdata", bus.wdata, bus.fifo_data);
            end
            if (!rstn) chk("o_waddr_reset", bus.waddr, 0);
        end
        if (bus.wr === 1'b1) begin
            if (bus.waddr[AW-1:0] != last_addr[AW-1:0] + 1'b1 && bus.waddr[AW-1:0] != 0)
                breaks <= breaks + 1;
            last_addr <= bus.waddr;
            wr_total  <= wr_total + 1;
        end
        if (bus.rd === 1'b1) rd_total <= rd_total + 1;
        pend_prev <= pend;
        if (pend === 1'b1 && !pend_prev) pend_rise <= pend_rise + 1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_pend(input string nm);
        int i = 0;
        while (i < 300 && pend !== 1'b1) begin
            step();
            i++;
        end
        chk(nm, pend, 1);
    endtask

    task automatic wait_wr(input string nm);
        int i = 0;
        while (i < 40 && bus.wr !== 1'b1) begin
            step();
            i++;
        end
        chk(nm, bus.wr, 1);
    endtask

    task automatic pulse_sof();
        sof = 1'b1;
        step();
        sof = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int wb, rb, pb, cyc;

    initial begin
        bus.almostempty = 1'b1;
        repeat (3) @(posedge clk);
        step();
        chk_en = 1'b1;
        step();
        chk("rst_o_rd", bus.rd, 0);
        chk("rst_o_wr", bus.wr, 0);
        chk("rst_o_waddr", bus.waddr, 0);
        chk("rst_o_rbank", rbank, 1);
        chk("rst_pending", pend, 0);
        chk("rst_frame_cnt", fcnt, 0);
        chk("rst_drop_cnt", dcnt, 0);
        rstn = 1'b1;
        bus.almostempty = 1'b0;
        wb = wr_total; rb = rd_total;

`ifdef FB_FRAME_DROP_EN
        begin
            int i = 0;
            while (i < 300 && !(dcnt == 16'd2 && pend === 1'b1)) begin
                step();
                i++;
            end
        end
        bus.almostempty = 1'b1;   // hold frame 3 pending
        chk("drop_cnt_after3", dcnt, 2);
        chk("drop_rbank", rbank, 1);
        chk("drop_pending", pend, 1);
        chk("drop_writes", wr_total - wb, 3 * N);
        repeat (4) step();
        chk("drop_cnt_hold", dcnt, 2);
        pulse_sof();
        chk("drop_swap_rbank", rbank, 0);
        chk("drop_swap_fcnt", fcnt, 1);
`else
        // Frame 1 into bank 0.
        wait_pend("f1_pending");
        chk("f1_reads", rd_total - rb, 16);
        chk("f1_writes", wr_total - wb, 16);
        chk("f1_last_addr", last_addr, 5'h0f);
        chk("f1_breaks", breaks, 0);
        chk("f1_rbank", rbank, 1);

        // PEND stalls with FIFO full, then display takes the frame.
        rb = rd_total;
        repeat (5) step();
        chk("pend_no_reads", rd_total - rb, 0);
        pulse_sof();
        chk("swap_rbank", rbank, 0);
        chk("swap_fcnt", fcnt, 1);
        chk("swap_pending", pend, 0);
        wait_wr("f2_first_wr");
        chk("f2_first_addr", bus.waddr, 5'h10);

        // Start-of-frame lands on the final write of frame 2.
        begin
            int i = 0;
            while (i < 60 && !(bus.wr === 1'b1 && bus.waddr == 5'h1f)) begin
                step();
                i++;
            end
        end
        chk("f2_final_wr_seen", bus.waddr, 5'h1f);
        pb = pend_rise;
        sof = 1'b1;
        bus.almostempty = 1'b1;
        step();
        sof = 1'b0;
        chk("imm_fcnt", fcnt, 2);
        chk("imm_rbank", rbank, 1);
        chk("imm_pending", pend, 0);
        chk("imm_no_pend_rise", pend_rise - pb, 0);

        // Frame 3 into bank 0 with a gappy FIFO.
        wb = wr_total; rb = rd_total;
        cyc = 0;
        while (cyc < 300 && pend !== 1'b1) begin
            bus.almostempty = ((cyc % 6) < 3);
            step();
            cyc++;
        end
        chk("gap_pending", pend, 1);
        chk("gap_writes", wr_total - wb, 16);
        chk("gap_reads", rd_total - rb, 16);
        chk("gap_breaks", breaks, 0);
        chk("gap_last_addr", last_addr, 5'h0f);

        // Swap, then flush frame 4 (bank 1) after 7 writes.
        bus.almostempty = 1'b0;
        pulse_sof();
        chk("f4_fcnt", fcnt, 3);
        chk("f4_rbank", rbank, 0);
        wb = wr_total;
        begin
            int i = 0;
            while (i < 60 && wr_total - wb < 7) begin
                step();
                i++;
            end
        end
        chk("fl_seven_writes", wr_total - wb, 7);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_o_rd", bus.rd, 0);
        chk("fl_o_wr", bus.wr, 0);
        chk("fl_rbank", rbank, 0);
        wb = wr_total;
        wait_wr("fl_next_wr");
        chk("fl_next_addr", bus.waddr, 5'h10);
        wait_pend("fl_pending");
        chk("fl_frame_writes", wr_total - wb, 16);

        // Flush while pending keeps the frame; flush beats start-of-frame.
        rb = rd_total;
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (3) step();
        chk("flpend_pending", pend, 1);
        chk("flpend_no_reads", rd_total - rb, 0);
        flush = 1'b1;
        sof = 1'b1;
        step();
        flush = 1'b0;
        sof = 1'b0;
        chk("flsof_pending", pend, 1);
        chk("flsof_rbank", rbank, 0);
        chk("flsof_fcnt", fcnt, 3);
        pulse_sof();
        chk("f5_rbank", rbank, 1);
        chk("f5_fcnt", fcnt, 4);

        // Reset in the middle of a frame.
        wb = wr_total;
        begin
            int i = 0;
            while (i < 40 && wr_total - wb < 3) begin
                step();
                i++;
            end
        end
        rstn = 1'b0;
        step();
        chk("mid_rst_o_wr", bus.wr, 0);
        chk("mid_rst_rbank", rbank, 1);
        chk("mid_rst_fcnt", fcnt, 0);
        rstn = 1'b1;
        wait_wr("mid_rst_first_wr");
        chk("mid_rst_first_addr", bus.waddr, 5'h00);
`endif
        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
